// File: rtl/abc_seq_responder_if.sv
// Bus bundle for abc_seq_responder: request/enable/clear inputs and response/status outputs.
// The orphan-tracking signals exist only when ABC_ORPHAN_CHK_EN is defined.
interface abc_seq_responder_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TS_W  = 32
) ();
  logic             en;
  logic             clr;
  logic             a;
  logic             b;
  logic             c;
  logic [1:0]       state;
  logic [CNT_W-1:0] match_cnt;
  logic [TS_W-1:0]  ts_cycle;
  logic             ts_valid;
`ifdef ABC_ORPHAN_CHK_EN
  logic [CNT_W-1:0] orphan_cnt;
  logic             orphan_flag;

  modport master (
    output en, clr, a, b,
    input  c, state, match_cnt, ts_cycle, ts_valid, orphan_cnt, orphan_flag
  );
  modport slave (
    input  en, clr, a, b,
    output c, state, match_cnt, ts_cycle, ts_valid, orphan_cnt, orphan_flag
  );
`else
  modport master (
    output en, clr, a, b,
    input  c, state, match_cnt, ts_cycle, ts_valid
  );
  modport slave (
    input  en, clr, a, b,
    output c, state, match_cnt, ts_cycle, ts_valid
  );
`endif
endinterface

// File: rtl/abc_seq_responder.sv
// Responder for the a-then-b handshake: pulses c one cycle after b follows a, with match
// counting and timestamp capture. Define ABC_ORPHAN_CHK_EN to add orphan-b tracking.
module abc_seq_responder #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TS_W  = 32
) (
  input logic                clk,
  input logic                rst,
  abc_seq_responder_if.slave bus_io
);

  // Encoding is {c, armed}, so the state register doubles as the c and armed flops.
  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StArmed     = 2'b01,
    StFire      = 2'b10,
    StArmedFire = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             fire;
  logic [TS_W-1:0]  cyc_q, cyc_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic             ts_valid_q, ts_valid_d;

  always_comb begin
    fire       = bus_io.en & state_q[0] & bus_io.b;
    state_d    = state_e'({fire, bus_io.en & bus_io.a});
    cyc_d      = cyc_q + TS_W'(1);
    ts_d       = ts_q;
    match_d    = match_q;
    ts_valid_d = ts_valid_q & ~bus_io.clr;
    // A fire on the same edge as clr restarts the count at one.
    if (fire) begin
      ts_d       = cyc_q;
      ts_valid_d = 1'b1;
      if (bus_io.clr)         match_d = CNT_W'(1);
      else if (match_q != '1) match_d = match_q + CNT_W'(1);
    end else if (bus_io.clr) begin
      match_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      ts_q       <= '0;
      match_q    <= '0;
      ts_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      ts_q       <= ts_d;
      match_q    <= match_d;
      ts_valid_q <= ts_valid_d;
    end
  end

  assign bus_io.c         = state_q[1];
  assign bus_io.state     = state_q;
  assign bus_io.match_cnt = match_q;
  assign bus_io.ts_cycle  = ts_q;
  assign bus_io.ts_valid  = ts_valid_q;

`ifdef ABC_ORPHAN_CHK_EN
  logic             orphan_ev;
  logic [CNT_W-1:0] orphan_q, orphan_d;
  logic             oflag_q, oflag_d;

  // b seen while not armed: it had no preceding a.
  always_comb begin
    orphan_ev = bus_io.en & bus_io.b & ~state_q[0];
    orphan_d  = bus_io.clr ? '0 : orphan_q;
    oflag_d   = oflag_q & ~bus_io.clr;
    if (orphan_ev) begin
      oflag_d = 1'b1;
      if (bus_io.clr)          orphan_d = CNT_W'(1);
      else if (orphan_q != '1) orphan_d = orphan_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_q <= '0;
      oflag_q  <= 1'b0;
    end else begin
      orphan_q <= orphan_d;
      oflag_q  <= oflag_d;
    end
  end

  assign bus_io.orphan_cnt  = orphan_q;
  assign bus_io.orphan_flag = oflag_q;
`endif

endmodule

// File: tb/tb_abc_seq_responder.sv
// Bench for abc_seq_responder: a full-width and a narrow instance share stimulus and are
// compared each cycle against a sequence-level reference model.
module tb_abc_seq_responder;

  logic clk;
  logic rst;

  abc_seq_responder_if #(.CNT_W(16), .TS_W(32)) if_f ();
  abc_seq_responder_if #(.CNT_W(2),  .TS_W(4))  if_s ();

  abc_seq_responder #(.CNT_W(16), .TS_W(32)) dut_f (.clk(clk), .rst(rst), .bus_io(if_f));
  abc_seq_responder #(.CNT_W(2),  .TS_W(4))  dut_s (.clk(clk), .rst(rst), .bus_io(if_s));

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 = full instance, 1 = narrow instance.
  longint unsigned cmax[2];
  longint unsigned tmod[2];
  longint unsigned m[2];
  longint unsigned ts[2];
  longint unsigned cyc[2];
  longint unsigned oc[2];
  bit              tv[2];
  bit              ofl[2];
  bit              a_pend;   // an enabled a was seen on the previous edge
  logic            exp_c;
  logic [1:0]      exp_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s.%s got=%0h exp=%0h", tag, nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "f.c",     64'(if_f.c),         64'(exp_c));
    chk(tag, "f.state", 64'(if_f.state),     64'(exp_state));
    chk(tag, "f.match", 64'(if_f.match_cnt), m[0]);
    chk(tag, "f.ts",    64'(if_f.ts_cycle),  ts[0]);
    chk(tag, "f.tsv",   64'(if_f.ts_valid),  64'(tv[0]));
    chk(tag, "s.c",     64'(if_s.c),         64'(exp_c));
    chk(tag, "s.state", 64'(if_s.state),     64'(exp_state));
    chk(tag, "s.match", 64'(if_s.match_cnt), m[1]);
    chk(tag, "s.ts",    64'(if_s.ts_cycle),  ts[1]);
    chk(tag, "s.tsv",   64'(if_s.ts_valid),  64'(tv[1]));
`ifdef ABC_ORPHAN_CHK_EN
    chk(tag, "f.ocnt",  64'(if_f.orphan_cnt),  oc[0]);
    chk(tag, "f.oflag", 64'(if_f.orphan_flag), 64'(ofl[0]));
    chk(tag, "s.ocnt",  64'(if_s.orphan_cnt),  oc[1]);
    chk(tag, "s.oflag", 64'(if_s.orphan_flag), 64'(ofl[1]));
`endif
  endtask

  task automatic model_reset();
    a_pend    = 1'b0;
    exp_c     = 1'b0;
    exp_state = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m[k] = 0; ts[k] = 0; cyc[k] = 0; oc[k] = 0; tv[k] = 1'b0; ofl[k] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, update the model, then check.
  task automatic step(input bit ia, input bit ib, input bit ien, input bit iclr,
                      input string tag);
    bit fire;
    bit orph;
    longint unsigned base;
    if_f.a = ia; if_f.b = ib; if_f.en = ien; if_f.clr = iclr;
    if_s.a = ia; if_s.b = ib; if_s.en = ien; if_s.clr = iclr;
    @(posedge clk);
    fire = ien && ib && a_pend;
    orph = ien && ib && !a_pend;
    for (int k = 0; k < 2; k++) begin
      base = iclr ? 0 : m[k];
      m[k] = fire ? ((base + 1 > cmax[k]) ? cmax[k] : base + 1) : base;
      if (fire) ts[k] = cyc[k];
      tv[k] = fire || (tv[k] && !iclr);
      base  = iclr ? 0 : oc[k];
      oc[k] = orph ? ((base + 1 > cmax[k]) ? cmax[k] : base + 1) : base;
      ofl[k] = orph || (ofl[k] && !iclr);
      cyc[k] = (cyc[k] + 1) % tmod[k];
    end
    exp_c     = fire;
    exp_state = {fire, ien && ia};
    a_pend    = ien && ia;
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    cmax[0] = 64'hFFFF;      cmax[1] = 3;
    tmod[0] = 64'h1_0000_0000; tmod[1] = 16;
    rst = 1'b1;
    if_f.a = 0; if_f.b = 0; if_f.en = 0; if_f.clr = 0;
    if_s.a = 0; if_s.b = 0; if_s.en = 0; if_s.clr = 0;
    model_reset();
    #11;
    check_all("reset");
    #1 rst = 1'b0;

    // Basic match: a sampled at 35 ns, b at 45 ns, c set on the 45 ns edge.
    step(0, 0, 1, 0, "bm_idle0");
    step(0, 0, 1, 0, "bm_idle1");
    step(1, 0, 1, 0, "bm_a");
    step(0, 1, 1, 0, "bm_b");
    chk("bm", "ts_const",    64'(if_f.ts_cycle),  64'd3);
    chk("bm", "match_const", 64'(if_f.match_cnt), 64'd1);
    step(0, 0, 1, 0, "bm_after");

    // Failed sequence.
    step(1, 0, 1, 0, "fs_a");
    chk("fs", "armed_const", 64'(if_f.state), 64'd1);
    step(0, 0, 1, 0, "fs_nob");
    step(0, 0, 1, 0, "fs_idle");

    // Overlap: a for 4 cycles, b on cycles 2-5.
    step(1, 0, 1, 0, "ov1");
    step(1, 1, 1, 0, "ov2");
    step(1, 1, 1, 0, "ov3");
    step(1, 1, 1, 0, "ov4");
    step(0, 1, 1, 0, "ov5");
    chk("ov", "f_match_const", 64'(if_f.match_cnt), 64'd5);
    chk("ov", "s_sat_const",   64'(if_s.match_cnt), 64'd3);
    step(0, 0, 1, 0, "ov_idle");

    // Async reset while armed, then en dropped on the b cycle.
    step(1, 0, 1, 0, "rs_a");
    pulse_reset("rs_async");
    step(0, 1, 1, 0, "rs_b");
    step(1, 0, 1, 0, "en_a");
    step(0, 1, 0, 0, "en_b");
    step(0, 0, 1, 0, "en_idle");

    // clr on the same edge as a fire.
    step(1, 0, 1, 0, "cf_a");
    step(0, 1, 1, 1, "cf_b");
    chk("cf", "match_const", 64'(if_f.match_cnt), 64'd1);
    step(0, 0, 1, 0, "cf_idle");

    // Timestamp wrap: capture at cycle 16 after reset.
    pulse_reset("wr_rst");
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, "wr_idle");
    step(1, 0, 1, 0, "wr_a");
    step(0, 1, 1, 0, "wr_b");
    chk("wr", "s_ts_const", 64'(if_s.ts_cycle), 64'd0);
    chk("wr", "f_ts_const", 64'(if_f.ts_cycle), 64'd16);

`ifdef ABC_ORPHAN_CHK_EN
    step(0, 0, 1, 1, "or_clr0");
    step(0, 1, 1, 0, "or_b1");
    step(0, 0, 1, 0, "or_gap");
    step(0, 1, 1, 0, "or_b2");
    chk("or", "cnt_const",  64'(if_f.orphan_cnt),  64'd2);
    chk("or", "flag_const", 64'(if_f.orphan_flag), 64'd1);
    step(0, 0, 1, 1, "or_clr1");
    chk("or", "cnt_clr",    64'(if_f.orphan_cnt),  64'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
